// File: rtl/a2d_arb.sv
// Two-requester round-robin arbiter for a shared A2D converter. Each grant runs two
// conversions (the first is a channel-settling dummy), separated by a guard delay.
module a2d_arb #(
  parameter int GUARD_CYC = 32,
  parameter int TO_CYC    = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [2:0]  chnnl0,
  input  logic        req1,
  input  logic [2:0]  chnnl1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] A2D_res
);

  typedef enum logic [2:0] {IDLE, WAIT1, GUARD, WAIT2, DONE} state_t;

  localparam logic [11:0] GUARD_LD = 12'(GUARD_CYC);
  localparam logic [11:0] TO_LIM   = 12'(TO_CYC - 1);

  state_t      state, state_nxt;
  logic [11:0] guard_cnt, guard_nxt;
  logic [11:0] wdog, wdog_nxt;
  logic        last_gnt, last_nxt;
  logic        gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err_nxt, strt_nxt;
  logic [2:0]  chnnl_nxt;
  logic [11:0] res_nxt;
  logic        pick1;

  // last_gnt=1 means requester 1 owned the converter last, so requester 0 wins a tie.
  assign pick1 = req1 & (~req0 | ~last_gnt);

  always_comb begin
    state_nxt = state;
    guard_nxt = guard_cnt;
    wdog_nxt  = wdog;
    last_nxt  = last_gnt;
    gnt0_nxt  = gnt0;
    gnt1_nxt  = gnt1;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    err_nxt   = 1'b0;
    strt_nxt  = 1'b0;
    chnnl_nxt = chnnl;
    res_nxt   = res;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt = WAIT1;
          strt_nxt  = 1'b1;
          wdog_nxt  = '0;
          last_nxt  = pick1;
          if (pick1) begin
            gnt1_nxt  = 1'b1;
            chnnl_nxt = chnnl1;
          end else begin
            gnt0_nxt  = 1'b1;
            chnnl_nxt = chnnl0;
          end
        end
      end
      WAIT1: begin
        // First result is discarded: the converter sampled the previous channel.
        if (cnv_cmplt) begin
          guard_nxt = GUARD_LD;
          state_nxt = GUARD;
        end else if (wdog == TO_LIM) begin
          state_nxt = DONE;
          done0_nxt = gnt0;
          done1_nxt = gnt1;
          err_nxt   = 1'b1;
        end else begin
          wdog_nxt = wdog + 12'd1;
        end
      end
      GUARD: begin
        if (guard_cnt <= 12'd1) begin
          strt_nxt  = 1'b1;
          wdog_nxt  = '0;
          guard_nxt = '0;
          state_nxt = WAIT2;
        end else begin
          guard_nxt = guard_cnt - 12'd1;
        end
      end
      WAIT2: begin
        if (cnv_cmplt) begin
          res_nxt   = A2D_res;
          state_nxt = DONE;
          done0_nxt = gnt0;
          done1_nxt = gnt1;
        end else if (wdog == TO_LIM) begin
          state_nxt = DONE;
          done0_nxt = gnt0;
          done1_nxt = gnt1;
          err_nxt   = 1'b1;
        end else begin
          wdog_nxt = wdog + 12'd1;
        end
      end
      DONE: begin
        gnt0_nxt  = 1'b0;
        gnt1_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      guard_cnt <= '0;
      wdog      <= '0;
      last_gnt  <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err       <= 1'b0;
      strt_cnv  <= 1'b0;
      chnnl     <= '0;
      res       <= '0;
    end else begin
      state     <= state_nxt;
      guard_cnt <= guard_nxt;
      wdog      <= wdog_nxt;
      last_gnt  <= last_nxt;
      gnt0      <= gnt0_nxt;
      gnt1      <= gnt1_nxt;
      done0     <= done0_nxt;
      done1     <= done1_nxt;
      err       <= err_nxt;
      strt_cnv  <= strt_nxt;
      chnnl     <= chnnl_nxt;
      res       <= res_nxt;
    end
  end

endmodule

// File: tb/tb_a2d_arb.sv
// Directed bench for a2d_arb: behavioural A2D responder, a monitor that logs
// start pulses, done pulses and grant order, and one task per scenario.
module tb_a2d_arb;
  localparam int GUARD = 32;
  localparam int TO    = 4095;

  logic        clk = 1'b0;
  logic        rst, req0, req1, cnv_cmplt;
  logic [2:0]  chnnl0, chnnl1, chnnl;
  logic        gnt0, gnt1, done0, done1, err, strt_cnv;
  logic [11:0] res, A2D_res;

  int checks = 0;
  int failures = 0;

  bit          a2d_on = 1'b1;
  bit          a2d_spur = 1'b0;
  int          a2d_dly = 3;
  logic [11:0] a2d_val = 12'h000;

  int cyc = 0;
  int strt_n = 0, s_last = 0, s_prev = 0, d0_n = 0, d1_n = 0, ovl = 0, ord_n = 0;
  logic [2:0] s_ch = 3'd0;
  int ord [16];
  logic g0_q = 1'b0, g1_q = 1'b0;

  a2d_arb #(.GUARD_CYC(GUARD), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req0(req0), .chnnl0(chnnl0), .req1(req1), .chnnl1(chnnl1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err), .res(res),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt), .A2D_res(A2D_res)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (strt_cnv) begin
      strt_n <= strt_n + 1;
      s_prev <= s_last;
      s_last <= cyc;
      s_ch   <= chnnl;
    end
    if (done0) d0_n <= d0_n + 1;
    if (done1) d1_n <= d1_n + 1;
    if (gnt0 && gnt1) ovl <= ovl + 1;
    if (gnt0 && !g0_q) begin ord[ord_n % 16] <= 0; ord_n <= ord_n + 1; end
    if (gnt1 && !g1_q) begin ord[ord_n % 16] <= 1; ord_n <= ord_n + 1; end
    g0_q <= gnt0;
    g1_q <= gnt1;
  end

  // A2D model: completes a conversion a2d_dly+1 edges after sampling strt_cnv,
  // optionally followed by one spurious completion pulse 11 edges later.
  initial begin
    cnv_cmplt = 1'b0;
    A2D_res   = 12'h000;
    forever begin
      @(posedge clk); #1;
      if (strt_cnv && a2d_on && !rst) begin
        repeat (a2d_dly) @(posedge clk);
        #1;
        if (!rst) begin
          cnv_cmplt = 1'b1; A2D_res = a2d_val;
          @(posedge clk); #1;
          cnv_cmplt = 1'b0;
          if (a2d_spur) begin
            repeat (10) @(posedge clk);
            #1;
            cnv_cmplt = 1'b1; A2D_res = 12'hFFF;
            @(posedge clk); #1;
            cnv_cmplt = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_done(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done0 || done1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_strt(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (strt_cnv) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; chnnl0 = 3'd0; chnnl1 = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt0, gnt1, done0, done1, err, strt_cnv} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000000", {gnt0, gnt1, done0, done1, err, strt_cnv});
    end
    checks++;
    if (chnnl !== 3'd0) begin failures++; $display("FAIL reset_chnnl: got %0h want 0", chnnl); end
    checks++;
    if (res !== 12'h000) begin failures++; $display("FAIL reset_res: got %0h want 0", res); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int s0, d0, t_done;
    a2d_on = 1'b1; a2d_dly = 40; a2d_val = 12'hA5C;
    s0 = strt_n; d0 = d0_n;
    req0 = 1'b1; chnnl0 = 3'h4;
    wait_done(400, ok);
    t_done = cyc;
    checks++;
    if (!ok) begin failures++; $display("FAIL single_done_timeout: got none want done0"); end
    checks++;
    if ({done0, done1, err, gnt0} !== 4'b1001) begin
      failures++; $display("FAIL single_flags: got done0/done1/err/gnt0=%b want 1001", {done0, done1, err, gnt0});
    end
    checks++;
    if (res !== 12'hA5C) begin failures++; $display("FAIL single_res: got %0h want a5c", res); end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({done0, gnt0} !== 2'b00) begin failures++; $display("FAIL single_release: got done0/gnt0=%b want 00", {done0, gnt0}); end
    repeat (3) @(negedge clk);
    checks++;
    if (strt_n - s0 != 2) begin failures++; $display("FAIL single_strt_cnt: got %0d want 2", strt_n - s0); end
    checks++;
    if (s_last - s_prev != 73) begin failures++; $display("FAIL single_strt_spacing: got %0d want 73", s_last - s_prev); end
    checks++;
    if (s_ch !== 3'h4) begin failures++; $display("FAIL single_chnnl: got %0h want 4", s_ch); end
    checks++;
    if (t_done - s_last != 41) begin failures++; $display("FAIL single_done_lat: got %0d want 41", t_done - s_last); end
    checks++;
    if (d0_n - d0 != 1) begin failures++; $display("FAIL single_done_cnt: got %0d want 1", d0_n - d0); end
    checks++;
    if (res !== 12'hA5C) begin failures++; $display("FAIL single_res_hold: got %0h want a5c", res); end
  endtask

  task automatic test_guard();
    bit ok;
    int s0;
    a2d_dly = 5; a2d_val = 12'h3C1; a2d_spur = 1'b1;
    s0 = strt_n;
    req1 = 1'b1; chnnl1 = 3'h2;
    wait_done(300, ok);
    checks++;
    if (!ok || done1 !== 1'b1) begin failures++; $display("FAIL guard_done1: got %b want 1", done1); end
    checks++;
    if ({err, res} !== {1'b0, 12'h3C1}) begin failures++; $display("FAIL guard_res: got err=%b res=%0h want err=0 res=3c1", err, res); end
    req1 = 1'b0;
    repeat (25) @(negedge clk);
    a2d_spur = 1'b0;
    checks++;
    if (s_last - s_prev != 38) begin failures++; $display("FAIL guard_spacing: got %0d want 38", s_last - s_prev); end
    checks++;
    if (strt_n - s0 != 2) begin failures++; $display("FAIL guard_strt_cnt: got %0d want 2", strt_n - s0); end
    checks++;
    if (s_ch !== 3'h2) begin failures++; $display("FAIL guard_chnnl: got %0h want 2", s_ch); end
    checks++;
    if ({res, gnt1} !== {12'h3C1, 1'b0}) begin failures++; $display("FAIL guard_idle_ignore: got res=%0h gnt1=%b want 3c1/0", res, gnt1); end
  endtask

  task automatic test_contention();
    bit ok;
    int o, ov;
    int exp_ord [4];
    exp_ord = '{0, 1, 0, 1};
    a2d_dly = 3; a2d_val = 12'h123;
    rst = 1'b1;
    @(negedge clk);
    req0 = 1'b1; req1 = 1'b1; chnnl0 = 3'h1; chnnl1 = 3'h7;
    o = ord_n; ov = ovl;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_done(300, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL contention_done_timeout: got none want done #%0d", k); end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ord_n - o != 4) begin failures++; $display("FAIL contention_grants: got %0d want 4", ord_n - o); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ord[(o + k) % 16] != exp_ord[k]) begin
        failures++; $display("FAIL contention_order[%0d]: got %0d want %0d", k, ord[(o + k) % 16], exp_ord[k]);
      end
    end
    checks++;
    if (ovl - ov != 0) begin failures++; $display("FAIL contention_overlap: got %0d want 0", ovl - ov); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    a2d_dly = 2; a2d_val = 12'h2CD;
    req0 = 1'b1; chnnl0 = 3'h5;
    wait_done(200, ok);
    checks++;
    if (!ok || done0 !== 1'b1) begin failures++; $display("FAIL b2b_first_done: got %b want 1", done0); end
    @(negedge clk);
    checks++;
    if ({gnt0, strt_cnv} !== 2'b00) begin failures++; $display("FAIL b2b_idle_gap: got gnt0/strt=%b want 00", {gnt0, strt_cnv}); end
    @(negedge clk);
    checks++;
    if ({gnt0, strt_cnv, chnnl} !== {2'b11, 3'h5}) begin
      failures++; $display("FAIL b2b_regrant: got gnt0/strt/chnnl=%b/%b/%0h want 1/1/5", gnt0, strt_cnv, chnnl);
    end
    req0 = 1'b0;
    wait_done(200, ok);
    checks++;
    if (!ok || done0 !== 1'b1 || res !== 12'h2CD) begin
      failures++; $display("FAIL b2b_second_done: got done0=%b res=%0h want 1/2cd", done0, res);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int s0, t_s;
    a2d_on = 1'b0;
    s0 = strt_n;
    req0 = 1'b1; chnnl0 = 3'h3;
    wait_strt(5, ok);
    t_s = cyc;
    checks++;
    if (!ok) begin failures++; $display("FAIL timeout_first_strt: got none want strt"); end
    wait_done(TO + 50, ok);
    checks++;
    if (!ok || {done0, err} !== 2'b11) begin failures++; $display("FAIL timeout_err: got done0/err=%b want 11", {done0, err}); end
    checks++;
    if (cyc - t_s != TO) begin failures++; $display("FAIL timeout_latency: got %0d want %0d", cyc - t_s, TO); end
    checks++;
    if (res !== 12'h2CD) begin failures++; $display("FAIL timeout_res_hold: got %0h want 2cd", res); end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if ({err, done0} !== 2'b00) begin failures++; $display("FAIL timeout_err_clear: got err/done0=%b want 00", {err, done0}); end
    repeat (3) @(negedge clk);
    checks++;
    if (strt_n - s0 != 1) begin failures++; $display("FAIL timeout_strt_cnt: got %0d want 1", strt_n - s0); end
    a2d_on = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int s0, d1;
    a2d_dly = 5; a2d_val = 12'h6A6;
    req1 = 1'b1; chnnl1 = 3'h6;
    wait_strt(5, ok);
    repeat (15) @(negedge clk);
    checks++;
    if (!ok || gnt1 !== 1'b1) begin failures++; $display("FAIL rstmid_pre_gnt1: got %b want 1", gnt1); end
    s0 = strt_n; d1 = d1_n;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, done0, done1, err, strt_cnv, chnnl, res} !== 21'b0) begin
      failures++; $display("FAIL rstmid_outputs: got gnt1=%b chnnl=%0h res=%0h want all 0", gnt1, chnnl, res);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_strt(5, ok);
    checks++;
    if (!ok || {gnt1, chnnl} !== {1'b1, 3'h6}) begin failures++; $display("FAIL rstmid_regrant: got gnt1=%b chnnl=%0h want 1/6", gnt1, chnnl); end
    wait_done(300, ok);
    checks++;
    if (!ok || done1 !== 1'b1 || res !== 12'h6A6) begin failures++; $display("FAIL rstmid_done: got done1=%b res=%0h want 1/6a6", done1, res); end
    req1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (d1_n - d1 != 1) begin failures++; $display("FAIL rstmid_done_cnt: got %0d want 1", d1_n - d1); end
    checks++;
    if (strt_n - s0 != 2) begin failures++; $display("FAIL rstmid_strt_cnt: got %0d want 2", strt_n - s0); end
  endtask

  task automatic test_early_release();
    bit ok;
    int s0, d0;
    a2d_dly = 4; a2d_val = 12'h0E7;
    s0 = strt_n; d0 = d0_n;
    req0 = 1'b1; chnnl0 = 3'h2;
    wait_strt(5, ok);
    @(negedge clk);
    req0 = 1'b0;
    wait_done(300, ok);
    checks++;
    if (!ok || done0 !== 1'b1 || res !== 12'h0E7) begin failures++; $display("FAIL early_done: got done0=%b res=%0h want 1/0e7", done0, res); end
    repeat (3) @(negedge clk);
    checks++;
    if (d0_n - d0 != 1 || strt_n - s0 != 2) begin
      failures++; $display("FAIL early_counts: got done=%0d strt=%0d want 1/2", d0_n - d0, strt_n - s0);
    end
    s0 = strt_n;
    req1 = 1'b1; chnnl1 = 3'h1;
    #2 req1 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (gnt1 !== 1'b0 || strt_n != s0) begin failures++; $display("FAIL glitch_no_grant: got gnt1=%b strt=%0d want 0/0", gnt1, strt_n - s0); end
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; chnnl0 = 3'd0; chnnl1 = 3'd0;
    test_reset();
    test_single();
    test_guard();
    test_contention();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_early_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
